uart_rx_sipo: RTL and testbench

UART receive path: serial-in, parallel-out deserializer paired with the transmit shift register on the other end of the link. It recovers frames of start(0), 8 data bits LSB first, parity, and stop(1), using a 16x oversampling enable. It delivers each received byte with a one-cycle valid pulse plus parity and framing error flags to the host-side logic.

---
 rtl/uart_rx_sipo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_sipo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sipo.sv
// UART receive deserializer: start, 8 data bits LSB first, parity, stop.
// Bit timing runs on an oversampling enable; each frame is reported with a one-cycle valid.
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       reg_clk,
    input  logic       reg_rst,
    input  logic       sample_tick,
    input  logic       serial_in,
    output logic [7:0] p_data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            par_bit;

    assign rx_s      = sync[1];
    assign dbg_state = state;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) sync <= 2'b11;
        else         sync <= {sync[0], serial_in};
    end

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
            par_bit    <= 1'b0;
            p_data_out <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state   <= START;
                            cnt     <= '0;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == HALF_M1) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_M1) begin
                            cnt       <= '0;
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (cnt == FULL_M1) begin
                            cnt     <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == FULL_M1) begin
                            cnt        <= '0;
                            p_data_out <= shift_reg;
                            parity_err <= par_bit ^ ((^shift_reg) ^ PARITY_ODD);
                            frame_err  <= ~rx_s;
                            data_valid <= 1'b1;
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state <= BREAK_WAIT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BREAK_WAIT: begin
                        // A held-low line must not be mistaken for new start bits.
                        if (rx_s) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: frame table plus break, glitch and reset-abort sequences.
module tb_uart_rx_sipo;

    logic       reg_clk = 1'b0;
    logic       reg_rst;
    logic       sample_tick;
    logic       serial_in;
    logic [7:0] p_data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] tick_div = 2'd0;
    logic [9:0] got_q[$];

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       gap;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_sipo #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
        .reg_clk    (reg_clk),
        .reg_rst    (reg_rst),
        .sample_tick(sample_tick),
        .serial_in  (serial_in),
        .p_data_out (p_data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy),
        .dbg_state  (dbg_state)
    );

    always #5 reg_clk = ~reg_clk;

    // sample_tick high for one clock out of every four
    always @(negedge reg_clk) begin
        tick_div    = tick_div + 2'd1;
        sample_tick = (tick_div == 2'd0);
    end

    always @(negedge reg_clk) begin
        if (data_valid) got_q.push_back({p_data_out, parity_err, frame_err});
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d, input logic perr, input logic ferr);
        logic [9:0] got;
        if (got_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no data_valid pulse, expected data %h", name, d);
        end else begin
            got = got_q.pop_front();
            chk({name, " data"}, {2'b00, got[9:2]}, {2'b00, d});
            chk({name, " parity_err"}, {9'd0, got[1]}, {9'd0, perr});
            chk({name, " frame_err"}, {9'd0, got[0]}, {9'd0, ferr});
        end
    endtask

    task automatic expect_none(input string name);
        chk(name, 10'(got_q.size()), 10'd0);
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLKS) @(negedge reg_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        reg_rst     = 1'b1;
        serial_in   = 1'b1;
        sample_tick = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0};

        repeat (3) @(negedge reg_clk);
        chk("reset outputs", {p_data_out, parity_err, frame_err}, 10'd0);
        chk("reset valid/busy", {8'd0, data_valid, rx_busy}, 10'd0);
        chk("reset state", {7'd0, dbg_state}, 10'd0);
        reg_rst = 1'b0;
        repeat (BIT_CLKS) @(negedge reg_clk);

        // Table: good frame, parity error and recovery, back-to-back burst
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, 1'b1);
            if (vecs[i].gap) repeat (BIT_CLKS) @(negedge reg_clk);
        end
        for (int i = 0; i < 6; i++)
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, 1'b0);
        expect_none("table extra pulses");
        chk("busy after frames", {9'd0, rx_busy}, 10'd0);

        // Stop bit low followed by a held break
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge reg_clk);
        chk("busy during break", {9'd0, rx_busy}, 10'd1);
        chk("state during break", {7'd0, dbg_state}, 10'd5);
        expect_frame("break frame", 8'h3C, 1'b0, 1'b1);
        expect_none("break extra pulses");
        serial_in = 1'b1;
        repeat (BIT_CLKS) @(negedge reg_clk);
        chk("busy after break", {9'd0, rx_busy}, 10'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (8) @(negedge reg_clk);
        expect_frame("post-break", 8'h55, 1'b0, 1'b0);
        expect_none("post-break extra");

        // Short glitch: shorter than half a bit, must be rejected
        serial_in = 1'b0;
        repeat (10) @(negedge reg_clk);
        chk("busy on glitch", {9'd0, rx_busy}, 10'd1);
        repeat (10) @(negedge reg_clk);
        serial_in = 1'b1;
        repeat (BIT_CLKS) @(negedge reg_clk);
        chk("busy after glitch", {9'd0, rx_busy}, 10'd0);
        expect_none("glitch pulses");

        // Reset in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        serial_in = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge reg_clk);
        chk("busy before abort", {9'd0, rx_busy}, 10'd1);
        reg_rst = 1'b1;
        repeat (3) @(negedge reg_clk);
        chk("abort outputs", {p_data_out, parity_err, frame_err}, 10'd0);
        chk("abort valid/busy", {8'd0, data_valid, rx_busy}, 10'd0);
        repeat (10) @(negedge reg_clk);
        reg_rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge reg_clk);
        expect_none("aborted frame pulse");
        chk("busy after abort", {9'd0, rx_busy}, 10'd0);
        send_frame(8'h7E, 1'b0, 1'b1);
        repeat (8) @(negedge reg_clk);
        expect_frame("after reset", 8'h7E, 1'b0, 1'b0);
        expect_none("after reset extra");
        chk("held data", {2'b00, p_data_out}, {2'b00, 8'h7E});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
